csr_machine_unit: RTL and testbench

Machine-mode CSR file and trap controller for the single-cycle RV32 core, sitting beside the register file and feeding the PC-select mux. It implements CSRRW/CSRRS/CSRRC (register and immediate forms), ecall/ebreak/mret, and two interrupt lines with MIE/MPIE stacking and vectored mtvec. It also provides 64-bit mcycle/minstret counters and illegal-CSR detection.

---
 rtl/csr_pkg.sv | 55 +++++
 rtl/csr_machine_unit_if.sv | 36 +++
 rtl/csr_counter64.sv | 30 +++
 rtl/csr_machine_unit.sv | 169 ++++++++++++++++
 tb/tb_csr_machine_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR unit.
// Holds CSR address constants, mcause codes, mstatus/mie bit indices,
// the csr_op encoding and the read-modify-write helper used by the top.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // misa: RV32, base ISA I
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // mcause codes (interrupt flag is added separately)
    localparam logic [4:0] CAUSE_EBREAK = 5'd3;
    localparam logic [4:0] CAUSE_TIMER  = 5'd7;
    localparam logic [4:0] CAUSE_ECALL  = 5'd11;
    localparam logic [4:0] CAUSE_EXT    = 5'd11;

    // Bit indices
    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIE_MTIE     = 7;
    localparam int unsigned MIE_MEIE     = 11;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    // New CSR value for a given operation applied to the old value.
    function automatic logic [31:0] csr_apply(input csr_op_e op,
                                              input logic [31:0] old,
                                              input logic [31:0] wdata);
        case (op)
            CSR_RW:  return wdata;
            CSR_RS:  return old | wdata;
            CSR_RC:  return old & ~wdata;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_machine_unit_if.sv
// csr_machine_unit_if: bundle between the core datapath and the CSR unit.
// master: core side (drives instruction/CSR/system/irq inputs).
// slave : CSR unit side (returns csr_rdata, csr_illegal, redirect, redirect_pc).
interface csr_machine_unit_if
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic            instr_valid;
    logic [XLEN-1:0] pc;
    csr_op_e         csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_src_zero;
    logic            ecall;
    logic            ebreak;
    logic            mret;
    logic            irq_timer;
    logic            irq_ext;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output instr_valid, pc, csr_op, csr_addr, csr_wdata, csr_src_zero,
        output ecall, ebreak, mret, irq_timer, irq_ext,
        input  csr_rdata, csr_illegal, redirect, redirect_pc
    );

    modport slave (
        input  instr_valid, pc, csr_op, csr_addr, csr_wdata, csr_src_zero,
        input  ecall, ebreak, mret, irq_timer, irq_ext,
        output csr_rdata, csr_illegal, redirect, redirect_pc
    );
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter built from two 32-bit halves.
// Ports: clk, rst (async, active-high), inc (count enable), wr_lo/wr_hi
// (load wdata into the low/high half), wdata, value (full 64-bit count).
// Any write suppresses that cycle's increment; the untouched half holds.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);
    logic [31:0] lo;
    logic [31:0] hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo <= '0;
            hi <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) lo <= wdata;
            if (wr_hi) hi <= wdata;
        end else if (inc) begin
            {hi, lo} <= {hi, lo} + 64'd1;
        end
    end

    assign value = {hi, lo};
endmodule

// File: rtl/csr_machine_unit.sv
// csr_machine_unit: machine-mode CSR file and trap controller.
// Ports: clk, rst (async, active-high) and bus (slave side of
// csr_machine_unit_if): instruction commit, CSR access, ecall/ebreak/mret,
// interrupt lines in; combinational csr_rdata, csr_illegal, redirect and
// redirect_pc out.
module csr_machine_unit
    import csr_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter logic [31:0] MTVEC_RESET  = 32'h8000_0000,
    parameter logic [31:0] HART_ID      = 32'd0,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input logic             clk,
    input logic             rst,
    csr_machine_unit_if.slave bus
);
    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("csr_machine_unit supports XLEN=32 only");
        end
    endgenerate

    // Architectural state
    logic        st_mie;
    logic        st_mpie;
    logic        st_mtie;
    logic        st_meie;
    logic [31:0] mtvec_r;
    logic [31:0] mscratch_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    // Read decode
    logic        known;
    logic        readonly;
    logic [31:0] old;

    always_comb begin
        known    = 1'b1;
        readonly = 1'b0;
        old      = '0;
        case (bus.csr_addr)
            CSR_MSTATUS:  old = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
            CSR_MISA:     begin old = MISA_VALUE; readonly = 1'b1; end
            CSR_MIE:      old = {20'b0, st_meie, 3'b0, st_mtie, 7'b0};
            CSR_MTVEC:    old = mtvec_r;
            CSR_MSCRATCH: old = mscratch_r;
            CSR_MEPC:     old = mepc_r;
            CSR_MCAUSE:   old = mcause_r;
            CSR_MIP: begin
                old      = {20'b0, bus.irq_ext, 3'b0, bus.irq_timer, 7'b0};
                readonly = 1'b1;
            end
            CSR_MHARTID:  begin old = HART_ID; readonly = 1'b1; end
            CSR_MCYCLE:    if (HAS_COUNTERS) old = mcycle[31:0];    else known = 1'b0;
            CSR_MCYCLEH:   if (HAS_COUNTERS) old = mcycle[63:32];   else known = 1'b0;
            CSR_MINSTRET:  if (HAS_COUNTERS) old = minstret[31:0];  else known = 1'b0;
            CSR_MINSTRETH: if (HAS_COUNTERS) old = minstret[63:32]; else known = 1'b0;
            default:      known = 1'b0;
        endcase
    end

    // RS/RC with a zero source are pure reads: no write, never illegal.
    logic is_write;
    assign is_write = (bus.csr_op == CSR_RW) ||
                      (((bus.csr_op == CSR_RS) || (bus.csr_op == CSR_RC)) && !bus.csr_src_zero);

    assign bus.csr_rdata   = old;
    assign bus.csr_illegal = (bus.csr_op != CSR_NONE) && (!known || (is_write && readonly));

    // Event priority: interrupt > ecall/ebreak > mret > CSR write.
    // rst gates every event so outputs reflect reset state while it is held.
    logic irq_pend;
    logic take_irq;
    logic take_exc;
    logic take_trap;
    logic take_mret;
    logic csr_wen;
    logic [4:0]  cause;
    logic [31:0] wval;
    logic [31:0] trap_pc;

    assign irq_pend  = st_mie && ((st_meie && bus.irq_ext) || (st_mtie && bus.irq_timer));
    assign take_irq  = !rst && bus.instr_valid && irq_pend;
    assign take_exc  = !rst && bus.instr_valid && !irq_pend && (bus.ecall || bus.ebreak);
    assign take_trap = take_irq || take_exc;
    assign take_mret = !rst && bus.instr_valid && !take_trap && bus.mret;
    assign csr_wen   = !rst && bus.instr_valid && !take_trap && !bus.mret &&
                       is_write && known && !readonly;

    always_comb begin
        if (take_irq)
            cause = (st_meie && bus.irq_ext) ? CAUSE_EXT : CAUSE_TIMER;
        else if (bus.ecall)
            cause = CAUSE_ECALL;
        else
            cause = CAUSE_EBREAK;
    end

    assign wval    = csr_apply(bus.csr_op, old, bus.csr_wdata);
    // Vectored mode offsets only interrupts; exceptions go to the base.
    assign trap_pc = {mtvec_r[31:2], 2'b00} +
                     ((mtvec_r[0] && take_irq) ? {25'b0, cause, 2'b00} : 32'd0);

    assign bus.redirect    = take_trap || take_mret;
    assign bus.redirect_pc = take_trap ? trap_pc : (take_mret ? mepc_r : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            st_mtie    <= 1'b0;
            st_meie    <= 1'b0;
            mtvec_r    <= MTVEC_RESET & ~32'h0000_0002;
            mscratch_r <= '0;
            mepc_r     <= '0;
            mcause_r   <= '0;
        end else if (take_trap) begin
            mepc_r   <= bus.pc & ~32'h0000_0003;
            mcause_r <= {take_irq, 26'b0, cause};
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
        end else if (take_mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (csr_wen) begin
            case (bus.csr_addr)
                CSR_MSTATUS: begin
                    st_mie  <= wval[MSTATUS_MIE];
                    st_mpie <= wval[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    st_mtie <= wval[MIE_MTIE];
                    st_meie <= wval[MIE_MEIE];
                end
                CSR_MTVEC:    mtvec_r    <= wval & ~32'h0000_0002;
                CSR_MSCRATCH: mscratch_r <= wval;
                CSR_MEPC:     mepc_r     <= wval & ~32'h0000_0003;
                CSR_MCAUSE:   mcause_r   <= wval;
                default: ;
            endcase
        end
    end

    // Counters: writes are decoded here; csr_wen already excludes unknown
    // addresses, so HAS_COUNTERS=0 disables counter writes as well.
    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (csr_wen && (bus.csr_addr == CSR_MCYCLE)),
        .wr_hi (csr_wen && (bus.csr_addr == CSR_MCYCLEH)),
        .wdata (wval),
        .value (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.instr_valid && !take_trap),
        .wr_lo (csr_wen && (bus.csr_addr == CSR_MINSTRET)),
        .wr_hi (csr_wen && (bus.csr_addr == CSR_MINSTRETH)),
        .wdata (wval),
        .value (minstret)
    );
endmodule

// File: tb/tb_csr_machine_unit.sv
// tb_csr_machine_unit: directed self-checking bench for csr_machine_unit.
// Inputs change #1 after the rising edge; outputs are checked on the
// falling edge; each CSR step occupies exactly one clock cycle.
module tb_csr_machine_unit;
    import csr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    csr_machine_unit_if #(.XLEN(32)) bus ();

    csr_machine_unit #(
        .XLEN        (32),
        .MTVEC_RESET (32'h8000_0000),
        .HART_ID     (32'd5),
        .HAS_COUNTERS(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.instr_valid  = 1'b0;
        bus.pc           = '0;
        bus.csr_op       = CSR_NONE;
        bus.csr_addr     = '0;
        bus.csr_wdata    = '0;
        bus.csr_src_zero = 1'b0;
        bus.ecall        = 1'b0;
        bus.ebreak       = 1'b0;
        bus.mret         = 1'b0;
    endtask

    // Present a committing CSR instruction and wait for the check point.
    task automatic csr(input csr_op_e op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic sz);
        bus.instr_valid  = 1'b1;
        bus.csr_op       = op;
        bus.csr_addr     = addr;
        bus.csr_wdata    = wd;
        bus.csr_src_zero = sz;
        @(negedge clk);
    endtask

    task automatic rd(input logic [11:0] addr);
        csr(CSR_RS, addr, 32'd0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        bus.irq_timer = 1'b0;
        bus.irq_ext   = 1'b0;

        // Reset held: an ecall must not redirect
        bus.instr_valid = 1'b1;
        bus.ecall       = 1'b1;
        bus.pc          = 32'h8000_0010;
        @(negedge clk);
        check("rst_redirect", bus.redirect, 1'b0);
        check("rst_redirect_pc", bus.redirect_pc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();

        // Reset values
        rd(CSR_MSTATUS);  check("reset_mstatus", bus.csr_rdata, 32'h0000_1800);
                          check("read_not_illegal", bus.csr_illegal, 1'b0); tick();
        rd(CSR_MTVEC);    check("reset_mtvec", bus.csr_rdata, 32'h8000_0000); tick();
        rd(CSR_MISA);     check("misa_read", bus.csr_rdata, 32'h4000_0100);
                          check("misa_read_legal", bus.csr_illegal, 1'b0); tick();
        rd(CSR_MHARTID);  check("mhartid", bus.csr_rdata, 32'd5); tick();

        // mtvec RW then readback
        csr(CSR_RW, CSR_MTVEC, 32'h8000_0103, 1'b0);
        check("mtvec_rw_old", bus.csr_rdata, 32'h8000_0000); tick();
        rd(CSR_MTVEC);    check("mtvec_bit1_zero", bus.csr_rdata, 32'h8000_0101); tick();

        // mscratch set/clear
        csr(CSR_RS, CSR_MSCRATCH, 32'h0F, 1'b0); tick();
        csr(CSR_RC, CSR_MSCRATCH, 32'h05, 1'b0);
        check("mscratch_rc_old", bus.csr_rdata, 32'h0F);
        check("mscratch_rc_legal", bus.csr_illegal, 1'b0); tick();
        rd(CSR_MSCRATCH); check("mscratch_val", bus.csr_rdata, 32'h0A); tick();

        // ecall with MIE=1
        csr(CSR_RS, CSR_MSTATUS, 32'h8, 1'b0); tick();
        bus.instr_valid = 1'b1;
        bus.ecall       = 1'b1;
        bus.pc          = 32'h8000_0040;
        @(negedge clk);
        check("ecall_redirect", bus.redirect, 1'b1);
        check("ecall_target", bus.redirect_pc, 32'h8000_0100); tick();
        rd(CSR_MEPC);     check("ecall_mepc", bus.csr_rdata, 32'h8000_0040); tick();
        rd(CSR_MCAUSE);   check("ecall_mcause", bus.csr_rdata, 32'd11); tick();
        rd(CSR_MSTATUS);  check("ecall_mstatus", bus.csr_rdata, 32'h0000_1880); tick();
        bus.instr_valid = 1'b1;
        bus.mret        = 1'b1;
        @(negedge clk);
        check("mret_redirect", bus.redirect, 1'b1);
        check("mret_target", bus.redirect_pc, 32'h8000_0040); tick();
        rd(CSR_MSTATUS);  check("mret_mstatus", bus.csr_rdata, 32'h0000_1888); tick();

        // Vectored interrupt, both lines high: external wins; CSR write dropped
        csr(CSR_RW, CSR_MTVEC, 32'h8000_0001, 1'b0); tick();
        csr(CSR_RW, CSR_MIE, 32'h880, 1'b0); tick();
        bus.irq_ext   = 1'b1;
        bus.irq_timer = 1'b1;
        rd(CSR_MIP);      check("mip_both", bus.csr_rdata, 32'h880);
        check("mip_read_irq_taken", bus.redirect, 1'b1); tick();
        rd(CSR_MCAUSE);   check("irq_mcause", bus.csr_rdata, 32'h8000_000B); tick();
        bus.pc = 32'h8000_0080;
        csr(CSR_RW, CSR_MSCRATCH, 32'hDEAD, 1'b0); // MIE now 0: no interrupt
        check("irq_masked", bus.redirect, 1'b0); tick();
        csr(CSR_RW, CSR_MSCRATCH, 32'h0A, 1'b0); tick();
        csr(CSR_RS, CSR_MSTATUS, 32'h8, 1'b0); tick();
        bus.pc = 32'h8000_0080;
        csr(CSR_RW, CSR_MSCRATCH, 32'hBEEF, 1'b0);
        check("irq_redirect", bus.redirect, 1'b1);
        check("irq_target", bus.redirect_pc, 32'h8000_002C); tick();
        bus.irq_ext   = 1'b0;
        bus.irq_timer = 1'b0;
        rd(CSR_MSCRATCH); check("irq_drops_write", bus.csr_rdata, 32'h0A); tick();
        rd(CSR_MEPC);     check("irq_mepc", bus.csr_rdata, 32'h8000_0080); tick();

        // ebreak in vectored mode goes to base
        bus.instr_valid = 1'b1;
        bus.ebreak      = 1'b1;
        bus.pc          = 32'h8000_00C4;
        @(negedge clk);
        check("ebreak_target", bus.redirect_pc, 32'h8000_0000); tick();
        rd(CSR_MCAUSE);   check("ebreak_mcause", bus.csr_rdata, 32'd3); tick();

        // mcycle carry into mcycleh
        csr(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 1'b0); tick();
        tick();
        tick();
        rd(CSR_MCYCLE);   check("mcycle_lo", bus.csr_rdata, 32'd1); tick();
        rd(CSR_MCYCLEH);  check("mcycle_hi", bus.csr_rdata, 32'd1); tick();

        // minstret: write wins, idle does not retire, reads do
        csr(CSR_RW, CSR_MINSTRET, 32'd0, 1'b0); tick();
        tick();
        rd(CSR_MINSTRET); check("minstret_0", bus.csr_rdata, 32'd0); tick();
        rd(CSR_MINSTRET); check("minstret_1", bus.csr_rdata, 32'd1); tick();

        // Illegal accesses
        csr(CSR_RW, CSR_MISA, 32'h0, 1'b0);
        check("misa_write_illegal", bus.csr_illegal, 1'b1); tick();
        rd(CSR_MISA);     check("misa_unchanged", bus.csr_rdata, 32'h4000_0100); tick();
        csr(CSR_RW, 12'h7C0, 32'h1234, 1'b0);
        check("unknown_illegal", bus.csr_illegal, 1'b1);
        check("unknown_rdata", bus.csr_rdata, 32'h0); tick();
        csr(CSR_RC, CSR_MHARTID, 32'h0, 1'b1);
        check("rc_zero_ro_legal", bus.csr_illegal, 1'b0); tick();

        // Reset mid-cycle with ecall pending
        bus.instr_valid = 1'b1;
        bus.ecall       = 1'b1;
        bus.pc          = 32'h8000_0200;
        #2;
        rst = 1'b1;
        #1;
        bus.csr_op = CSR_RS; bus.csr_src_zero = 1'b1; bus.csr_addr = CSR_MEPC;
        @(negedge clk);
        check("midrst_redirect", bus.redirect, 1'b0);
        check("midrst_mepc", bus.csr_rdata, 32'h0);
        bus.csr_addr = CSR_MSCRATCH; #1;
        check("midrst_mscratch", bus.csr_rdata, 32'h0);
        bus.csr_addr = CSR_MTVEC; #1;
        check("midrst_mtvec", bus.csr_rdata, 32'h8000_0000);
        bus.csr_addr = CSR_MIE; #1;
        check("midrst_mie", bus.csr_rdata, 32'h0);
        bus.csr_addr = CSR_MCAUSE; #1;
        check("midrst_mcause", bus.csr_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        rd(CSR_MEPC);     check("postrst_mepc", bus.csr_rdata, 32'h0); tick();
        rd(CSR_MSTATUS);  check("postrst_mstatus", bus.csr_rdata, 32'h0000_1800); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
